// File: rtl/signext_if.sv
// signext_if: instruction/opcode-class request bus and registered immediate result.
interface signext_if #(parameter int XLEN = 32);
  logic [31:0] instruct;
  logic [6:0] typ;
  logic [XLEN-1:0] out;
  modport master(output instruct, typ, input out);
  modport slave(input instruct, typ, output out);
endinterface

// File: rtl/signext.sv
// signext: registered RISC-V immediate generator selecting the format by opcode class.
module signext #(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst_n,
  signext_if.slave bus
);
  logic [31:0] i;
  logic [XLEN-1:0] imm;
  logic s;
  assign i = bus.instruct;
  assign s = i[31];
  // case rather than a ternary chain so an unknown typ falls to zero instead of merging
  always_comb begin
    imm = '0;
    case (bus.typ)
      7'b0010011, 7'b0000011, 7'b1100111: imm = {{(XLEN-12){s}}, i[31:20]};
      7'b0100011: imm = {{(XLEN-12){s}}, i[31:25], i[11:7]};
      7'b1100011: imm = {{(XLEN-13){s}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm = {{(XLEN-32){s}}, i[31:12], 12'h000};
      7'b1101111: imm = {{(XLEN-21){s}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.out <= '0;
    else bus.out <= imm;
endmodule

// File: tb/tb_signext.sv
// tb_signext: scoreboard bench; stimulus pushes expected immediates, a monitor pops and compares.
module tb_signext;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  signext_if #(.XLEN(32)) bus ();
  signext #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Immediate value as an integer built from weighted instruction bits; sign bit carries negative weight.
  function automatic logic [31:0] model(input logic [31:0] i, input logic [6:0] t);
    int s;
    int v;
    s = int'(i[31]);
    v = 0;
    case (t)
      7'b0010011, 7'b0000011, 7'b1100111: v = -2048 * s + int'(i[30:20]);
      7'b0100011: v = -2048 * s + 32 * int'(i[30:25]) + int'(i[11:7]);
      7'b1100011: v = -4096 * s + 2048 * int'(i[7]) + 32 * int'(i[30:25]) + 2 * int'(i[11:8]);
      7'b0110111, 7'b0010111: v = int'(i & 32'hFFFF_F000);
      7'b1101111: v = -1048576 * s + 4096 * int'(i[19:12]) + 2048 * int'(i[20]) + 2 * int'(i[30:21]);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic apply(input logic [31:0] i, input logic [6:0] t, input logic [31:0] exp);
    @(negedge clk);
    bus.instruct = i;
    bus.typ = t;
    q.push_back(exp);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() != 0) chk("pipe", bus.out, q.pop_front());
    end
  end

  initial begin
    logic [6:0] tl[11];
    logic [31:0] ri;
    logic [6:0] rt;
    tl = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b0110111,
           7'b0010111, 7'b1101111, 7'b0110011, 7'b0000000, 7'b1111111};
    rst_n = 1'b0;
    bus.instruct = 32'hFFFF_FFFF;
    bus.typ = 7'b0010011;
    #2 chk("reset_immediate", bus.out, 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", bus.out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(32'hFFFF_FFFF);
    apply(32'h0000_0FFF, 7'b0010011, 32'h0000_0000);
    apply(32'hFFFF_F800, 7'b0010011, 32'hFFFF_FFFF);
    apply(32'h0000_0FFF, 7'b0000011, 32'h0000_0000);
    apply(32'hFFFF_F800, 7'b0000011, 32'hFFFF_FFFF);
    apply(32'h0000_0FFF, 7'b0100011, 32'h0000_001F);
    apply(32'hFFFF_F800, 7'b0100011, 32'hFFFF_FFF0);
    apply(32'hFFFF_F800, 7'b1100011, 32'hFFFF_F7F0);
    apply(32'h8000_0000, 7'b1101111, 32'hFFF0_0000);
    apply(32'hABCD_E0B7, 7'b0110111, 32'hABCD_E000);
    apply(32'hABCD_E0B7, 7'b0010111, 32'hABCD_E000);
    apply(32'hFFFF_FFFF, 7'b0110011, 32'h0000_0000);
    apply(32'hFFFF_FFFF, 7'bxxxxxxx, 32'h0000_0000);
    apply(32'h7FF0_0000, 7'b1100111, 32'h0000_07FF);
    apply(32'hFFFF_FFFF, 7'b0010011, 32'hFFFF_FFFF);
    drain();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("reset_midrun", bus.out, 32'h0);
    @(posedge clk);
    #1 chk("reset_midrun_hold", bus.out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(32'hFFFF_FFFF);
    for (int k = 0; k < 400; k++) begin
      ri = $urandom;
      rt = (k % 8 == 7) ? 7'($urandom) : tl[$urandom_range(0, 10)];
      apply(ri, rt, model(ri, rt));
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
